// File: rtl/instr_mem_responder.sv
// Memory side of the instruction fetch req/grant/rvalid handshake: word-addressed
// store with side-load port, programmable grant delay, response latency and stall.
module instr_mem_responder #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MEM_WORDS       = 1024,
    parameter int GNT_DELAY       = 0,
    parameter int RVALID_DELAY    = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_req,
    input  logic [ADDR_WIDTH-1:0] instr_addr,
    output logic                  instr_grant,
    output logic                  instr_rvalid,
    output logic [DATA_WIDTH-1:0] instr_rdata,
    input  logic                  stall_gnt,
    input  logic                  load_we,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [3:0]            outstanding
);

    localparam int         IDX_W   = $clog2(MEM_WORDS);
    localparam logic [3:0] GNT_DLY = 4'(GNT_DELAY);
    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];
    logic [IDX_W-1:0]        rd_idx;
    logic [IDX_W-1:0]        ld_idx;
    logic                    accept;
    logic                    unused_addr_bits;

    logic [3:0]              gcnt_q, gcnt_d;
    logic [3:0]              outstanding_q, outstanding_d;
    logic [RVALID_DELAY-1:0] vld_q, vld_d;
    logic [DATA_WIDTH-1:0]   dat_q [RVALID_DELAY];
    logic [DATA_WIDTH-1:0]   dat_d [RVALID_DELAY];

    assign rd_idx           = instr_addr[2 +: IDX_W];
    assign ld_idx           = load_addr[2 +: IDX_W];
    assign unused_addr_bits = ^{instr_addr, load_addr};

    assign instr_rvalid = vld_q[RVALID_DELAY-1];
    assign instr_rdata  = dat_q[RVALID_DELAY-1];
    assign outstanding  = outstanding_q;

    // A response leaving this cycle frees a slot, so grant may bypass a full count.
    always_comb begin
        instr_grant = rst_n && instr_req && (gcnt_q == GNT_DLY) && !stall_gnt &&
                      ((outstanding_q < MAX_OUT) || instr_rvalid);
        accept      = instr_req && instr_grant;
    end

    always_comb begin
        gcnt_d = gcnt_q;
        if (!instr_req || accept) begin
            gcnt_d = '0;
        end else if (gcnt_q != GNT_DLY) begin
            gcnt_d = gcnt_q + 4'd1;
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !instr_rvalid) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (!accept && instr_rvalid) begin
            outstanding_d = outstanding_q - 4'd1;
        end
    end

    // Data stages only load behind a valid word, so the last stage holds the
    // most recently returned instruction between strobes.
    always_comb begin
        vld_d[0] = accept;
        dat_d[0] = accept ? mem[rd_idx] : dat_q[0];
        for (int unsigned i = 1; i < RVALID_DELAY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt_q        <= '0;
            outstanding_q <= '0;
            vld_q         <= '0;
            for (int unsigned i = 0; i < RVALID_DELAY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            gcnt_q        <= gcnt_d;
            outstanding_q <= outstanding_d;
            vld_q         <= vld_d;
            for (int unsigned i = 0; i < RVALID_DELAY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[ld_idx] <= load_data;
        end
    end

    a_rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) instr_rvalid |-> (outstanding_q != '0));

    a_no_grant_in_stall: assert property (
        @(posedge clk) disable iff (!rst_n) stall_gnt |-> !instr_grant);

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: four differently configured instances share
// stimulus; a scoreboard checks every response's data, order and latency.
module tb_instr_mem_responder;

    localparam int NI = 4;
    localparam int GD  [NI] = '{0, 3, 0, 0};
    localparam int RVD [NI] = '{1, 1, 4, 3};
    localparam int MXO [NI] = '{2, 2, 1, 2};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        stall;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    logic        gnt [NI];
    logic        rv  [NI];
    logic [31:0] rd  [NI];
    logic [3:0]  os  [NI];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model [1024];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        instr_mem_responder #(
            .ADDR_WIDTH      (32),
            .DATA_WIDTH      (32),
            .MEM_WORDS       (1024),
            .GNT_DELAY       (GD[g]),
            .RVALID_DELAY    (RVD[g]),
            .MAX_OUTSTANDING (MXO[g])
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .instr_req    (req),
            .instr_addr   (addr),
            .instr_grant  (gnt[g]),
            .instr_rvalid (rv[g]),
            .instr_rdata  (rd[g]),
            .stall_gnt    (stall),
            .load_we      (load_we),
            .load_addr    (load_addr),
            .load_data    (load_data),
            .outstanding  (os[g])
        );
    end

    // Scoreboard: pushes on acceptance (data from the bench's own memory model,
    // read before any same-edge load), pops and checks on every rvalid.
    always @(negedge clk) begin
        int cnt;
        int idx;
        cyc++;
        if (!rst_n) begin
            sb.delete();
        end else begin
            for (int i = 0; i < NI; i++) begin
                cnt = 0;
                idx = -1;
                for (int k = 0; k < sb.size(); k++) begin
                    if (sb[k].inst == i) begin
                        cnt++;
                        if (idx < 0) idx = k;
                    end
                end
                total++;
                if (os[i] !== 4'(cnt)) begin
                    bad++;
                    $display("FAIL sb_outstanding inst%0d cyc%0d got=%0d exp=%0d", i, cyc, os[i], cnt);
                end
                if (rv[i] === 1'b1) begin
                    total++;
                    if (idx < 0) begin
                        bad++;
                        $display("FAIL sb_unexpected_rvalid inst%0d cyc%0d got=1 exp=0", i, cyc);
                    end else begin
                        if (sb[idx].due !== cyc || rd[i] !== sb[idx].data) begin
                            bad++;
                            $display("FAIL sb_response inst%0d got=%h@%0d exp=%h@%0d",
                                     i, rd[i], cyc, sb[idx].data, sb[idx].due);
                        end
                        sb.delete(idx);
                    end
                end
            end
            for (int k = 0; k < sb.size(); ) begin
                if (sb[k].due <= cyc) begin
                    total++;
                    bad++;
                    $display("FAIL sb_missing_rvalid inst%0d cyc%0d got=0 exp=1 (due %0d)",
                             sb[k].inst, cyc, sb[k].due);
                    sb.delete(k);
                end else begin
                    k++;
                end
            end
            for (int i = 0; i < NI; i++) begin
                if (req && gnt[i]) begin
                    sb.push_back('{inst: i, due: cyc + RVD[i], data: model[addr[11:2]]});
                end
            end
        end
        if (load_we) model[load_addr[11:2]] = load_data;
    end

    task automatic cyc_drive(input logic r, input logic [31:0] a, input logic st,
                             input logic we, input logic [31:0] ld);
        @(posedge clk);
        #1;
        req       = r;
        addr      = a;
        stall     = st;
        load_we   = we;
        load_addr = a;
        load_data = ld;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc_drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 8; k++) begin
            cyc_drive(1'b0, 32'(k * 4), 1'b0, 1'b1, 32'hA0 + 32'(k));
        end
        cyc_drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < NI; i++) begin
            total++;
            if (gnt[i] !== 1'b0 || rv[i] !== 1'b0 || rd[i] !== 32'h0 || os[i] !== 4'h0) begin
                bad++;
                $display("FAIL reset_values inst%0d got gnt=%b rv=%b rd=%h os=%0d exp all zero",
                         i, gnt[i], rv[i], rd[i], os[i]);
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);
    endtask

    task automatic test_burst();
        for (int i = 0; i < 5; i++) begin
            cyc_drive(i < 4, 32'(i * 4), 1'b0, 1'b0, 32'h0);
            total++;
            if (gnt[0] !== (i < 4)) begin
                bad++;
                $display("FAIL burst_grant c%0d got=%b exp=%b", i, gnt[0], i < 4);
            end
            if (i >= 1) begin
                total++;
                if (rv[0] !== 1'b1 || rd[0] !== 32'hA0 + 32'(i - 1)) begin
                    bad++;
                    $display("FAIL burst_rdata c%0d got rv=%b rd=%h exp rv=1 rd=%h",
                             i, rv[0], rd[0], 32'hA0 + 32'(i - 1));
                end
            end
        end
        idle(8);
    endtask

    task automatic test_gnt_delay();
        for (int i = 1; i <= 4; i++) begin
            cyc_drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
            total++;
            if (gnt[1] !== (i == 4)) begin
                bad++;
                $display("FAIL gdly_grant c%0d got=%b exp=%b", i, gnt[1], i == 4);
            end
        end
        cyc_drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        total++;
        if (rv[1] !== 1'b1 || rd[1] !== 32'hA4) begin
            bad++;
            $display("FAIL gdly_rdata got rv=%b rd=%h exp rv=1 rd=000000a4", rv[1], rd[1]);
        end
        for (int i = 0; i < 4; i++) begin
            cyc_drive(i < 2, 32'h14, 1'b0, 1'b0, 32'h0);
            total++;
            if (gnt[1] !== 1'b0 || rv[1] !== 1'b0) begin
                bad++;
                $display("FAIL gdly_dropped c%0d got gnt=%b rv=%b exp 0 0", i, gnt[1], rv[1]);
            end
        end
        for (int i = 1; i <= 4; i++) begin
            cyc_drive(1'b1, 32'h14, 1'b0, 1'b0, 32'h0);
            total++;
            if (gnt[1] !== (i == 4)) begin
                bad++;
                $display("FAIL gdly_restart c%0d got=%b exp=%b", i, gnt[1], i == 4);
            end
        end
        idle(8);
    endtask

    task automatic test_max_outstanding();
        for (int i = 1; i <= 13; i++) begin
            cyc_drive(1'b1, 32'h18, 1'b0, 1'b0, 32'h0);
            total++;
            if (gnt[2] !== ((i % 4) == 1) || os[2] > 4'd1) begin
                bad++;
                $display("FAIL maxout c%0d got gnt=%b os=%0d exp gnt=%b os<=1",
                         i, gnt[2], os[2], (i % 4) == 1);
            end
        end
        idle(8);
    endtask

    task automatic test_stall();
        logic st;
        for (int i = 1; i <= 10; i++) begin
            st = (i >= 3 && i <= 7);
            cyc_drive(1'b1, 32'h1C, st, 1'b0, 32'h0);
            total++;
            if (gnt[0] !== !st) begin
                bad++;
                $display("FAIL stall_grant c%0d got=%b exp=%b", i, gnt[0], !st);
            end
            if (i == 3) begin
                total++;
                if (rv[0] !== 1'b1 || rd[0] !== 32'hA7) begin
                    bad++;
                    $display("FAIL stall_inflight got rv=%b rd=%h exp rv=1 rd=000000a7", rv[0], rd[0]);
                end
            end
        end
        idle(8);
    endtask

    task automatic test_read_before_write();
        logic [31:0] exp_rd [4] = '{32'hA2, 32'hDEAD, 32'hDEAD, 32'hA1};
        logic [31:0] adr    [5] = '{32'h8, 32'h8, 32'h1008, 32'h1004, 32'h0};
        for (int i = 0; i < 5; i++) begin
            cyc_drive(i < 4, adr[i], 1'b0, i == 0, 32'hDEAD);
            if (i == 0) begin
                total++;
                if (gnt[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL rbw_grant got=%b exp=1", gnt[0]);
                end
            end else begin
                total++;
                if (rv[0] !== 1'b1 || rd[0] !== exp_rd[i-1]) begin
                    bad++;
                    $display("FAIL rbw_rdata c%0d got rv=%b rd=%h exp rv=1 rd=%h",
                             i, rv[0], rd[0], exp_rd[i-1]);
                end
            end
        end
        idle(8);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            cyc_drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
            total++;
            if (gnt[3] !== 1'b1) begin
                bad++;
                $display("FAIL rstmid_grant c%0d got=%b exp=1", i, gnt[3]);
            end
        end
        @(posedge clk);
        #1 req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            total++;
            if (gnt[i] !== 1'b0 || rv[i] !== 1'b0 || rd[i] !== 32'h0 || os[i] !== 4'h0) begin
                bad++;
                $display("FAIL rstmid_async inst%0d got gnt=%b rv=%b rd=%h os=%0d exp all zero",
                         i, gnt[i], rv[i], rd[i], os[i]);
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc_drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            total++;
            if (rv[3] !== 1'b0 || os[3] !== 4'h0) begin
                bad++;
                $display("FAIL rstmid_flushed c%0d got rv=%b os=%0d exp 0 0", i, rv[3], os[3]);
            end
        end
        cyc_drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
        cyc_drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        total++;
        if (rv[0] !== 1'b1 || rd[0] !== 32'hA1) begin
            bad++;
            $display("FAIL rstmid_mem_kept got rv=%b rd=%h exp rv=1 rd=000000a1", rv[0], rd[0]);
        end
        idle(8);
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 1'b0;
        addr      = '0;
        stall     = 1'b0;
        load_we   = 1'b0;
        load_addr = '0;
        load_data = '0;
        test_reset();
        test_burst();
        test_gnt_delay();
        test_max_outstanding();
        test_stall();
        test_read_before_write();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drained got=%0d pending exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
